// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST sequencer.
package mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mbist_state_t;
  typedef enum logic [1:0] {W0, W1, R0, R1} march_op_t;

  typedef struct packed {
    logic      down;
    logic      two_ops;
    march_op_t op0;
    march_op_t op1;
  } elem_t;

  localparam int NUM_ELEM = 6;

  // Padded to 8 so any 3-bit element index (including the look-ahead past M5) stays in range.
  localparam elem_t ELEM_TBL [0:7] = '{
    '{1'b0, 1'b0, W0, W0},
    '{1'b0, 1'b1, R0, W1},
    '{1'b0, 1'b1, R1, W0},
    '{1'b1, 1'b1, R0, W1},
    '{1'b1, 1'b1, R1, W0},
    '{1'b0, 1'b0, R0, R0},
    '{1'b0, 1'b0, R0, R0},
    '{1'b0, 1'b0, R0, R0}
  };

  function automatic logic is_read(input march_op_t op);
    return (op == R0) || (op == R1);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter with terminal-address flag.
module mbist_addr_gen #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_down,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              term
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    addr <= '0;
    else if (load) addr <= load_down ? '1 : '0;
    else if (en)   addr <= down ? addr - 1'b1 : addr + 1'b1;
  end

  assign term = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: walks the element table over one SRAM and logs the first read mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  mbist_state_t      state;
  logic [2:0]        elem_idx;
  logic              op_idx;
  logic [ADDR_W-1:0] addr;
  logic              term;

  elem_t     cur;
  march_op_t op;
  logic      run, start_ok, last_op, elem_end, last_elem;
  logic      ag_load, ag_load_down, ag_en;

  assign cur       = ELEM_TBL[elem_idx];
  assign op        = op_idx ? cur.op1 : cur.op0;
  assign run       = (state == RUN);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign last_op   = !cur.two_ops || op_idx;
  assign elem_end  = run && last_op && term;
  assign last_elem = (elem_idx == 3'(NUM_ELEM - 1));

  // Reload the counter at test start and at each element boundary, using the next element's direction.
  assign ag_load      = start_ok || (elem_end && !last_elem);
  assign ag_load_down = !start_ok && ELEM_TBL[3'(elem_idx + 3'd1)].down;
  assign ag_en        = run && last_op && !term;

  mbist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (ag_load),
    .load_down(ag_load_down),
    .en       (ag_en),
    .down     (cur.down),
    .addr     (addr),
    .term     (term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      elem_idx <= '0;
      op_idx   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state    <= RUN;
          elem_idx <= '0;
          op_idx   <= 1'b0;
        end
        RUN: begin
          if (last_op) begin
            op_idx <= 1'b0;
            if (term) begin
              if (last_elem) state <= DRAIN;
              else           elem_idx <= 3'(elem_idx + 3'd1);
            end
          end else begin
            op_idx <= 1'b1;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

  assign mem_re    = run && is_read(op);
  assign mem_we    = run && !is_read(op);
  assign mem_addr  = run ? addr : '0;
  assign mem_wdata = (run && op == W1) ? '1 : '0;
  assign busy      = run || (state == DRAIN);
  assign done      = (state == DONE);

  // Compare pipe: capture read context now, check the returned data next cycle.
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0]        cmp_elem;
  logic              mismatch;

  assign mismatch = cmp_vld && (mem_rdata != cmp_exp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_vld   <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      cmp_vld <= mem_re;
      if (mem_re) begin
        cmp_exp  <= (op == R1) ? '1 : '0;
        cmp_addr <= addr;
        cmp_elem <= elem_idx;
      end
      if (start_ok) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !fail) begin
        fail      <= 1'b1;
        fail_addr <= cmp_addr;
        fail_elem <= cmp_elem;
      end
    end
  end

endmodule
